l1_dcache_wb: RTL and testbench
===============================

# l1_dcache_wb

Direct-mapped, write-back, write-allocate L1 data cache between the MEM pipeline stage (port p1) and the 256-bit line-wide `Data_Memory` (port mem). It serves word loads and stores from the pipeline in zero wait states on a hit. On a miss it stalls the pipeline, writes back a dirty victim line, fills the new line, then completes the access as a hit. Capacity: 32 lines × 32 B = 1 KB.

## Interface
Parameters:
- `LINES`, 32: number of lines (index width = log2).
- `LINE_BITS`, 256: line width in bits.
- `TAG_W`, 22: address tag width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `p1_addr_i`  in  32  byte address; [4:2] word, [9:5] index, [31:10] tag.
- `p1_data_i`  in  32  store data.
- `p1_MemRead_i`  in  1  load request.
- `p1_MemWrite_i`  in  1  store request (wins if both high).
- `p1_data_o`  out  32  load data, valid when stall low.
- `p1_stall_o`  out  1  pipeline stall.
- `mem_data_i`  in  256  fill line.
- `mem_ack_i`  in  1  one-cycle completion pulse.
- `mem_data_o`  out  256  write-back line.
- `mem_addr_o`  out  32  line address, [4:0]=0.
- `mem_enable_o`  out  1  request, held until ack.
- `mem_write_o`  out  1  1=write-back, 0=fill.

## Operation
- Tag entry 24 b: {valid, dirty, tag[21:0]}. Hit = req & valid & tag match.
- States: IDLE(0), MISS, WRITEBACK, READMISS, READMISSOK.
- IDLE:
  - Hit: no stall; load returns word [32k+31:32k], k=addr[4:2]; store merges the word into the line and sets dirty.
  - Miss: `p1_stall_o`=1 combinationally; next edge → MISS.
- MISS: stall. If victim valid&dirty → WRITEBACK with enable=1, write=1, addr={victim tag, index, 5'b0}, data=victim line. Else → READMISS with enable=1, write=0, addr={req tag, index, 5'b0}.
- WRITEBACK: hold outputs; on ack → READMISS, enable stays 1, write→0, addr→fill address.
- READMISS: hold; on ack, write `mem_data_i` into data SRAM and {1,0,req tag} into tag SRAM; enable→0; → READMISSOK.
- READMISSOK: stall; next edge → IDLE, where the access re-evaluates as a hit (store merges then).
- No request (both low) in IDLE: no stall, no SRAM write, `p1_data_o` don't-care.
- Request inputs held stable by the pipeline while stalled; changes mid-miss are unsupported.

## Timing
- Reset (async assert): state IDLE; `mem_enable_o`, `mem_write_o`, `p1_stall_o` = 0; `mem_addr_o`, `mem_data_o` = 0; all tag entries cleared (valid=0). Data SRAM not reset.
- Reset mid-miss: transaction abandoned, no SRAM update, enable drops immediately.
- Hit latency 0 (combinational read; store write at edge).
- Clean miss: stall cycles = N+3, N = READMISS cycles up to and including ack.
- Dirty miss: N_wb+N+3.
- `mem_enable_o`/`mem_write_o`/`mem_addr_o`/`mem_data_o` are registered; ack sampled only in WRITEBACK/READMISS; stray ack elsewhere ignored.
- Memory must accept a new request in the cycle after ack with enable continuously high.

## Structure
- Package `dcache_pkg`: state enum, field widths (TAG_W, INDEX_W, OFFSET_W), tag-entry bit positions (VALID_BIT=23, DIRTY_BIT=22).
- Sub-module `dcache_sram` (sync write, async read, width/depth params), instanced as `dcache_tag_sram` (24 b, tag entries reset by `rst_i`) and `dcache_data_sram` (256 b). Hierarchy names fixed; the testbench probes `state`, `sram_dirty`, the `p1_*` ports, and `memory[]` arrays.

## Test plan
- Cold load 0x0000, memory returns line with word0=0x5, ack after 10 cycles → stall 13 cycles, `p1_data_o`=0x00000005, entry 0 = {1,0,0}.
- Store 0x0004←0xDEADBEEF after fill → no stall, line word1 updated, dirty=1; reload 0x0004 hits with 0xDEADBEEF.
- Load 0x0400 (same index 0, tag 1) with dirty line 0 → write-back to addr 0x0000 with the dirty line, then fill from 0x0400; stall = N_wb+N+3.
- Store miss 0x0024←0x12345678 on clean invalid line → fill 0x0020, then word1 merged, dirty=1, stall N+3.
- Reset asserted in READMISS → enable low, state IDLE, entry remains invalid; replayed load misses again.
- Both MemRead and MemWrite high on hit → treated as store; ack pulse in IDLE → ignored, no state change.

Source files
------------

// File: rtl/l1_dcache_wb_pkg.sv
// Shared types and field layout for the direct-mapped write-back L1 data cache.
// Tag entries are {valid, dirty, tag}; addresses split as tag | index | word | byte.
package dcache_pkg;

  localparam int TAG_W       = 22;
  localparam int INDEX_W     = 5;
  localparam int OFFSET_W    = 5;
  localparam int WORD_W      = 32;
  localparam int TAG_ENTRY_W = TAG_W + 2;
  localparam int VALID_BIT   = 23;
  localparam int DIRTY_BIT   = 22;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MISS       = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_READMISS   = 3'd3,
    ST_READMISSOK = 3'd4
  } dcache_state_e;

endpackage

// File: rtl/l1_dcache_wb_if.sv
// Bus bundles for the cache: the pipeline-facing port (p1) and the line-wide memory port (mem).
// The pipeline is master on p1; the cache is master on mem.
interface dcache_p1_if;
  logic [31:0] p1_addr_i;
  logic [31:0] p1_data_i;
  logic        p1_MemRead_i;
  logic        p1_MemWrite_i;
  logic [31:0] p1_data_o;
  logic        p1_stall_o;

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
    input  p1_data_o, p1_stall_o
  );

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
    output p1_data_o, p1_stall_o
  );
endinterface

interface dcache_mem_if;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  modport master (
    input  mem_data_i, mem_ack_i,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport slave (
    output mem_data_i, mem_ack_i,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/l1_dcache_wb_sram.sv
// Single-port array with synchronous write and asynchronous read.
// RESET_EN selects whether the contents are cleared by the asynchronous reset.
module dcache_sram #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 32,
  parameter bit RESET_EN = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] memory [DEPTH];

  assign rdata_o = memory[addr_i];

  if (RESET_EN) begin : g_reset
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        for (int i = 0; i < DEPTH; i++) memory[i] <= '0;
      end else if (we_i) begin
        memory[addr_i] <= wdata_i;
      end
    end
  end else begin : g_no_reset
    // NOTE: large data arrays are left unreset so they map onto plain RAM; validity lives in the tag array.
    logic unused_rst;
    assign unused_rst = rst_i;

    always_ff @(posedge clk_i) begin
      if (we_i) memory[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a line-wide memory port.
// Hits complete in zero wait states; misses write back a dirty victim, fill, then replay as a hit.
module l1_dcache_wb #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = dcache_pkg::TAG_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_p1_if.slave   p1,
  dcache_mem_if.master mem
);
  import dcache_pkg::*;

  localparam int IDX_W   = $clog2(LINES);
  localparam int ENTRY_W = TAG_W + 2;
  localparam int WORDS   = LINE_BITS / WORD_W;
  localparam int WSEL_W  = $clog2(WORDS);

  dcache_state_e state_q, state_d;
  dcache_state_e state;

  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_write_q, mem_write_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

  logic [ENTRY_W-1:0]   tag_rdata, tag_wdata;
  logic                 tag_we;
  logic [LINE_BITS-1:0] data_rdata, data_wdata, merged_line;
  logic                 data_we;

  logic                 sram_valid, sram_dirty;
  logic [TAG_W-1:0]     sram_tag;
  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_index;
  logic [WSEL_W-1:0]    req_word;
  logic [31:0]          fill_addr;
  logic                 req, is_store, hit, stall;
  logic                 unused_byte_bits;

  assign state = state_q;

  assign req_tag          = p1.p1_addr_i[31 -: TAG_W];
  assign req_index        = p1.p1_addr_i[OFFSET_W +: IDX_W];
  assign req_word         = p1.p1_addr_i[2 +: WSEL_W];
  assign unused_byte_bits = ^p1.p1_addr_i[1:0];
  assign fill_addr        = {req_tag, req_index, {OFFSET_W{1'b0}}};

  assign sram_valid = tag_rdata[VALID_BIT];
  assign sram_dirty = tag_rdata[DIRTY_BIT];
  assign sram_tag   = tag_rdata[TAG_W-1:0];

  // A store wins when both request strobes are high.
  assign is_store = p1.p1_MemWrite_i;
  assign req      = p1.p1_MemRead_i | p1.p1_MemWrite_i;
  assign hit      = req & sram_valid & (sram_tag == req_tag);

  dcache_sram #(
    .WIDTH    (ENTRY_W),
    .DEPTH    (LINES),
    .RESET_EN (1'b1)
  ) dcache_tag_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (tag_we),
    .addr_i  (req_index),
    .wdata_i (tag_wdata),
    .rdata_o (tag_rdata)
  );

  dcache_sram #(
    .WIDTH    (LINE_BITS),
    .DEPTH    (LINES),
    .RESET_EN (1'b0)
  ) dcache_data_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (data_we),
    .addr_i  (req_index),
    .wdata_i (data_wdata),
    .rdata_o (data_rdata)
  );

  always_comb begin
    merged_line = data_rdata;
    merged_line[req_word*WORD_W +: WORD_W] = p1.p1_data_i;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    stall        = 1'b1;
    tag_we       = 1'b0;
    tag_wdata    = {1'b1, 1'b0, req_tag};
    data_we      = 1'b0;
    data_wdata   = mem.mem_data_i;

    unique case (state_q)
      ST_IDLE: begin
        stall = req & ~hit;
        if (hit && is_store) begin
          data_we    = 1'b1;
          data_wdata = merged_line;
          tag_we     = 1'b1;
          tag_wdata  = {1'b1, 1'b1, req_tag};
        end
        if (req && !hit) state_d = ST_MISS;
      end
      ST_MISS: begin
        mem_enable_d = 1'b1;
        if (sram_valid && sram_dirty) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {sram_tag, req_index, {OFFSET_W{1'b0}}};
          mem_data_d  = data_rdata;
          state_d     = ST_WRITEBACK;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = fill_addr;
          state_d     = ST_READMISS;
        end
      end
      ST_WRITEBACK: begin
        // Enable stays high so the fill request follows the write-back back-to-back.
        if (mem.mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = fill_addr;
          state_d     = ST_READMISS;
        end
      end
      ST_READMISS: begin
        if (mem.mem_ack_i) begin
          data_we      = 1'b1;
          tag_we       = 1'b1;
          mem_enable_d = 1'b0;
          state_d      = ST_READMISSOK;
        end
      end
      ST_READMISSOK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign p1.p1_stall_o   = stall;
  assign p1.p1_data_o    = data_rdata[req_word*WORD_W +: WORD_W];
  assign mem.mem_enable_o = mem_enable_q;
  assign mem.mem_write_o  = mem_write_q;
  assign mem.mem_addr_o   = mem_addr_q;
  assign mem.mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_l1_dcache_wb.sv
// Directed self-checking bench for l1_dcache_wb: cold/dirty/store misses, hits, stray ack, reset mid-miss.
// The memory side is driven from the stimulus sequence with a per-access ack latency.
module tb_l1_dcache_wb;
  import dcache_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dcache_p1_if  p1_if ();
  dcache_mem_if mem_if ();

  l1_dcache_wb dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .p1    (p1_if.slave),
    .mem   (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  // Starts at a negedge; returns at a negedge after the hit cycle has been clocked.
  task automatic do_access(
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    input  logic         rd,
    input  logic         wr,
    input  int           lat_wb,
    input  int           lat_fill,
    input  logic [255:0] fill,
    output int           stalls,
    output logic [31:0]  rdata,
    output logic         wb_seen,
    output logic [31:0]  wb_addr,
    output logic [255:0] wb_data,
    output logic [31:0]  fill_addr,
    output logic         timed_out
  );
    int req_cyc;
    stalls    = 0;
    rdata     = '0;
    wb_seen   = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    fill_addr = '0;
    timed_out = 1'b1;
    req_cyc   = 0;
    p1_if.p1_addr_i     = addr;
    p1_if.p1_data_i     = wdata;
    p1_if.p1_MemRead_i  = rd;
    p1_if.p1_MemWrite_i = wr;
    mem_if.mem_data_i   = fill;
    #1;
    for (int c = 0; c < 300; c++) begin
      if (!p1_if.p1_stall_o) begin
        rdata     = p1_if.p1_data_o;
        timed_out = 1'b0;
        break;
      end
      stalls++;
      if (mem_if.mem_enable_o) begin
        req_cyc++;
        if (mem_if.mem_write_o) begin
          wb_seen = 1'b1;
          wb_addr = mem_if.mem_addr_o;
          wb_data = mem_if.mem_data_o;
          mem_if.mem_ack_i = (req_cyc == lat_wb);
        end else begin
          fill_addr = mem_if.mem_addr_o;
          mem_if.mem_ack_i = (req_cyc == lat_fill);
        end
        if (mem_if.mem_ack_i) req_cyc = 0;
      end
      @(posedge clk);
      @(negedge clk);
      mem_if.mem_ack_i = 1'b0;
      #1;
    end
    @(posedge clk);
    @(negedge clk);
    p1_if.p1_MemRead_i  = 1'b0;
    p1_if.p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    int           stalls;
    logic [31:0]  rdata, wb_addr, fill_addr;
    logic [255:0] wb_data, exp_line;
    logic         wb_seen, timed_out, reached;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    p1_if.p1_addr_i     = '0;
    p1_if.p1_data_i     = '0;
    p1_if.p1_MemRead_i  = 1'b0;
    p1_if.p1_MemWrite_i = 1'b0;
    mem_if.mem_data_i   = '0;
    mem_if.mem_ack_i    = 1'b0;

    // Reset state
    #1;
    check("rst_state",   dut.state, ST_IDLE);
    check("rst_stall",   p1_if.p1_stall_o, 1'b0);
    check("rst_enable",  mem_if.mem_enable_o, 1'b0);
    check("rst_write",   mem_if.mem_write_o, 1'b0);
    check("rst_addr",    mem_if.mem_addr_o, 32'h0);
    check("rst_data",    mem_if.mem_data_o, 256'h0);
    check("rst_tag0",    dut.dcache_tag_sram.memory[0], 24'h0);
    check("rst_tag31",   dut.dcache_tag_sram.memory[31], 24'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold load 0x0000, fill ack on 10th cycle
    do_access(32'h0000_0000, 32'h0, 1'b1, 1'b0, 0, 10, make_line(32'h5),
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("cold_timeout", timed_out, 1'b0);
    check("cold_stalls",  stalls, 13);
    check("cold_rdata",   rdata, 32'h0000_0005);
    check("cold_no_wb",   wb_seen, 1'b0);
    check("cold_faddr",   fill_addr, 32'h0000_0000);
    check("cold_tag0",    dut.dcache_tag_sram.memory[0], 24'h80_0000);

    // Store hit 0x0004
    do_access(32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 0, '0,
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("st_timeout", timed_out, 1'b0);
    check("st_stalls",  stalls, 0);
    check("st_word1",   dut.dcache_data_sram.memory[0][63:32], 32'hDEAD_BEEF);
    check("st_word0",   dut.dcache_data_sram.memory[0][31:0], 32'h0000_0005);
    check("st_tag0",    dut.dcache_tag_sram.memory[0], 24'hC0_0000);
    check("st_dirty",   dut.sram_dirty, 1'b1);

    // Reload 0x0004 hits
    do_access(32'h0000_0004, 32'h0, 1'b1, 1'b0, 0, 0, '0,
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("rl_timeout", timed_out, 1'b0);
    check("rl_stalls",  stalls, 0);
    check("rl_rdata",   rdata, 32'hDEAD_BEEF);

    // Dirty miss: load 0x0400, write-back ack on 3rd cycle, fill ack on 5th
    exp_line = make_line(32'h5);
    exp_line[63:32] = 32'hDEAD_BEEF;
    do_access(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3, 5, make_line(32'h100),
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("dm_timeout", timed_out, 1'b0);
    check("dm_stalls",  stalls, 11);
    check("dm_wb_seen", wb_seen, 1'b1);
    check("dm_wb_addr", wb_addr, 32'h0000_0000);
    check("dm_wb_data", wb_data, exp_line);
    check("dm_faddr",   fill_addr, 32'h0000_0400);
    check("dm_rdata",   rdata, 32'h0000_0100);
    check("dm_tag0",    dut.dcache_tag_sram.memory[0], 24'h80_0001);

    // Store miss 0x0024 on invalid line 1, fill ack on 4th cycle
    do_access(32'h0000_0024, 32'h1234_5678, 1'b0, 1'b1, 0, 4, make_line(32'h200),
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("sm_timeout", timed_out, 1'b0);
    check("sm_stalls",  stalls, 7);
    check("sm_no_wb",   wb_seen, 1'b0);
    check("sm_faddr",   fill_addr, 32'h0000_0020);
    check("sm_word1",   dut.dcache_data_sram.memory[1][63:32], 32'h1234_5678);
    check("sm_word0",   dut.dcache_data_sram.memory[1][31:0], 32'h0000_0200);
    check("sm_tag1",    dut.dcache_tag_sram.memory[1], 24'hC0_0000);

    // Read and write both high on a hit: treated as a store
    do_access(32'h0000_0028, 32'hCAFE_F00D, 1'b1, 1'b1, 0, 0, '0,
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("rw_timeout", timed_out, 1'b0);
    check("rw_stalls",  stalls, 0);
    check("rw_word2",   dut.dcache_data_sram.memory[1][95:64], 32'hCAFE_F00D);

    // Stray ack in IDLE with no request
    mem_if.mem_ack_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_if.mem_ack_i = 1'b0;
    #1;
    check("stray_state",  dut.state, ST_IDLE);
    check("stray_enable", mem_if.mem_enable_o, 1'b0);
    check("stray_stall",  p1_if.p1_stall_o, 1'b0);

    // Reset asserted during READMISS of load 0x0840
    p1_if.p1_addr_i    = 32'h0000_0840;
    p1_if.p1_MemRead_i = 1'b1;
    mem_if.mem_data_i  = make_line(32'h300);
    #1;
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (dut.state == ST_READMISS) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    check("rm_reached", reached, 1'b1);
    check("rm_enable",  mem_if.mem_enable_o, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_rst_enable", mem_if.mem_enable_o, 1'b0);
    check("rm_rst_state",  dut.state, ST_IDLE);
    check("rm_rst_tag2",   dut.dcache_tag_sram.memory[2][VALID_BIT], 1'b0);
    check("rm_rst_tag0",   dut.dcache_tag_sram.memory[0], 24'h0);
    @(negedge clk);
    p1_if.p1_MemRead_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Replayed load misses again
    do_access(32'h0000_0840, 32'h0, 1'b1, 1'b0, 0, 2, make_line(32'h300),
              stalls, rdata, wb_seen, wb_addr, wb_data, fill_addr, timed_out);
    check("rp_timeout", timed_out, 1'b0);
    check("rp_stalls",  stalls, 5);
    check("rp_faddr",   fill_addr, 32'h0000_0840);
    check("rp_rdata",   rdata, 32'h0000_0300);
    check("rp_tag2",    dut.dcache_tag_sram.memory[2], 24'h80_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
